// File: rtl/inst_mem.sv
// -----------------------------------------------------------------------------
// inst_mem -- loadable instruction memory with a one-cycle fetch port.
//
// A program is streamed in during a load session. Fetches are then served
// from the stored image, one response per request, with a fixed one-cycle
// latency.
//
// Request/response semantics: there is no ready/backpressure on either
// side. A fetch request (ce=1 with pc_addr) is accepted on a rising edge
// only while SERVE is active and no load_start arrives on the same edge;
// its response shows up in the next cycle as inst_valid=1 with either the
// stored word or a fault (addr_err=1, inst=NOP_INST). Requests made outside
// SERVE are dropped, not queued. A load word (load_en=1 with load_data) is
// consumed on every rising edge spent in LOAD; load_last has no meaning
// unless load_en is also high.
//
// Ports:
//   clk         single clock, rising-edge
//   rst         asynchronous active-low reset
//   ce          fetch request enable
//   pc_addr     byte address of the requested instruction
//   inst        returned instruction word (NOP_INST when no valid word)
//   inst_valid  inst carries a response this cycle
//   addr_err    the response is a fault (misaligned or out of range)
//   load_start  begin a program-load session
//   load_en     load_data is valid this cycle
//   load_last   the current load_data is the final word of the session
//   load_data   program word to store
//   load_done   one-cycle pulse after the final write of a session
//   busy        high while in the LOAD state
//   state_dbg   current FSM state (0=IDLE, 1=LOAD, 2=SERVE) for debug
// -----------------------------------------------------------------------------
module inst_mem #(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [31:0] NOP_INST   = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic [31:0] pc_addr,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        addr_err,
    input  logic        load_start,
    input  logic        load_en,
    input  logic        load_last,
    input  logic [31:0] load_data,
    output logic        load_done,
    output logic        busy,
    output logic [1:0]  state_dbg
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] WCNT_MAX = {DEPTH_LOG2{1'b1}};
    localparam logic [DEPTH_LOG2-1:0] WCNT_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SERVE = 2'd2
    } state_t;

    // Storage has no reset: contents survive rst so an aborted session keeps
    // the words it already wrote.
    logic [31:0] mem [DEPTH];

    state_t                state_q,      state_d;
    logic [DEPTH_LOG2-1:0] wcnt_q,       wcnt_d;
    logic [31:0]           inst_q,       inst_d;
    logic                  inst_valid_q, inst_valid_d;
    logic                  addr_err_q,   addr_err_d;
    logic                  load_done_q,  load_done_d;

    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  req_fault;

    assign rd_idx       = pc_addr[DEPTH_LOG2+1:2];
    assign misaligned   = |pc_addr[1:0];
    // Any address bit above the word index makes the request out of range.
    assign out_of_range = (pc_addr >> (DEPTH_LOG2 + 2)) != 32'd0;
    assign req_fault    = misaligned | out_of_range;

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        inst_d       = NOP_INST;
        inst_valid_d = 1'b0;
        addr_err_d   = 1'b0;
        load_done_d  = 1'b0;
        mem_we       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                    wcnt_d  = '0;
                end
            end

            ST_LOAD: begin
                // load_start is deliberately not looked at here.
                if (load_en) begin
                    mem_we = 1'b1;
                    if (load_last || (wcnt_q == WCNT_MAX)) begin
                        // Counter holds on the final write so it never wraps.
                        state_d     = ST_SERVE;
                        load_done_d = 1'b1;
                    end else begin
                        wcnt_d = wcnt_q + WCNT_ONE;
                    end
                end
            end

            ST_SERVE: begin
                // A new session wins over a simultaneous fetch: the fetch is
                // dropped and memory is not read.
                if (load_start) begin
                    state_d = ST_LOAD;
                    wcnt_d  = '0;
                end else if (ce) begin
                    inst_valid_d = 1'b1;
                    if (req_fault) begin
                        addr_err_d = 1'b1;
                    end else begin
                        inst_d = mem[rd_idx];
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            wcnt_q       <= '0;
            inst_q       <= NOP_INST;
            inst_valid_q <= 1'b0;
            addr_err_q   <= 1'b0;
            load_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            addr_err_q   <= addr_err_d;
            load_done_q  <= load_done_d;
        end
    end

    // mem_we is only ever high in LOAD, and reset forces the state out of
    // LOAD asynchronously, so no write can land while rst is low.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wcnt_q] <= load_data;
        end
    end

    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign addr_err   = addr_err_q;
    assign load_done  = load_done_q;
    assign busy       = (state_q == ST_LOAD);
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_inst_mem.sv
// -----------------------------------------------------------------------------
// tb_inst_mem -- directed + randomized bench for inst_mem.
//
// The reference model is a plain word array plus a write pointer that
// follows the load-session rules; fetch expectations come from address
// arithmetic (aligned and below 4*DEPTH means legal).
// -----------------------------------------------------------------------------
module tb_inst_mem;

  localparam int          DL    = 10;
  localparam int          DEPTH = 1 << DL;
  localparam logic [31:0] NOP   = 32'h00000000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  logic        ce = 1'b0;
  logic [31:0] pc_addr = '0;
  logic [31:0] inst;
  logic        inst_valid;
  logic        addr_err;
  logic        load_start = 1'b0;
  logic        load_en = 1'b0;
  logic        load_last = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_done;
  logic        busy;
  logic [1:0]  state_dbg;

  inst_mem #(.DEPTH_LOG2(DL), .NOP_INST(NOP)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .pc_addr    (pc_addr),
    .inst       (inst),
    .inst_valid (inst_valid),
    .addr_err   (addr_err),
    .load_start (load_start),
    .load_en    (load_en),
    .load_last  (load_last),
    .load_data  (load_data),
    .load_done  (load_done),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // ---------------- model / scoreboard ----------------
  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic bit is_fault(input logic [31:0] a);
    return ((a % 4) != 0) || (a >= 4 * DEPTH);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one fetch this cycle (ce stays high so calls chain back-to-back)
  // and check the response that appears after the edge.
  task automatic fetch(input logic [31:0] a);
    logic [31:0] e;
    ce      = 1'b1;
    pc_addr = a;
    exp_q.push_back(is_fault(a) ? NOP : model_mem[a[DL+1:2]]);
    step();
    e = exp_q.pop_front();
    check("fetch_valid", {31'b0, inst_valid}, 32'd1);
    check("fetch_err", {31'b0, addr_err}, {31'b0, is_fault(a)});
    check("fetch_inst", inst, e);
  endtask

  task automatic idle_check();
    ce = 1'b0;
    step();
    check("idle_valid", {31'b0, inst_valid}, 32'd0);
    check("idle_err", {31'b0, addr_err}, 32'd0);
    check("idle_inst", inst, NOP);
  endtask

  task automatic load_word(input logic [31:0] d, input logic last);
    load_en   = 1'b1;
    load_data = d;
    load_last = last;
    step();
    load_en   = 1'b0;
    load_last = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] prog [3];
    int          busy_cycles;
    int          idx;
    int          cyc;
    int          r;
    logic [31:0] d;

    prog[0] = 32'h24010001;
    prog[1] = 32'h24020002;
    prog[2] = 32'h00221820;

    // Reset values while rst is held low.
    ce = 1'b1;
    #12;
    check("rst_inst", inst, NOP);
    check("rst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_err", {31'b0, addr_err}, 32'd0);
    check("rst_done", {31'b0, load_done}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    #5 rst = 1'b1;

    // Requests before any load are dropped.
    pc_addr = 32'h0;
    repeat (3) begin
      step();
      check("idle_drop_valid", {31'b0, inst_valid}, 32'd0);
      check("idle_drop_inst", inst, NOP);
    end
    ce = 1'b0;

    // Three-word load session.
    busy_cycles = 0;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    if (busy) busy_cycles++;
    check("load_busy_start", {31'b0, busy}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      model_mem[i] = prog[i];
      load_word(prog[i], i == 2);
      if (busy) busy_cycles++;
      check("load_done_pulse", {31'b0, load_done}, (i == 2) ? 32'd1 : 32'd0);
    end
    check("load_busy_cycles", busy_cycles, 32'd3);
    step();
    check("load_done_once", {31'b0, load_done}, 32'd0);

    // Back-to-back fetches, then faults.
    fetch(32'h0);
    fetch(32'h4);
    fetch(32'h8);
    idle_check();
    fetch(32'h00000006);
    fetch(32'h00001000);
    idle_check();

    // Randomized serve traffic over the three loaded words.
    repeat (60) begin
      r = $urandom_range(0, 3);
      case (r)
        0: idle_check();
        1: fetch(($urandom_range(0, 2) * 4) | $urandom_range(1, 3));
        2: fetch($urandom | 32'h00001000);
        default: fetch($urandom_range(0, 2) * 4);
      endcase
    end
    idle_check();

    // Full 1024-word load, load_last never set with load_en; gaps carry
    // load_last/load_start noise and ce stays high (all must be ignored).
    ce = 1'b1;
    pc_addr = 32'h0;
    load_start = 1'b1;
    step();
    check("full_busy_start", {31'b0, busy}, 32'd1);
    check("full_drop_valid", {31'b0, inst_valid}, 32'd0);
    idx = 0;
    cyc = 0;
    while (idx < DEPTH && cyc < 4000) begin
      cyc++;
      if ($urandom_range(0, 3) == 0) begin
        load_en    = 1'b0;
        load_last  = 1'($urandom_range(0, 1));
        load_start = 1'($urandom_range(0, 1));
        step();
        check("full_gap_busy", {31'b0, busy}, 32'd1);
        check("full_gap_done", {31'b0, load_done}, 32'd0);
      end else begin
        d = $urandom;
        load_en    = 1'b1;
        load_last  = 1'b0;
        load_data  = d;
        load_start = 1'($urandom_range(0, 1));
        model_mem[idx] = d;
        idx++;
        step();
        check("full_busy", {31'b0, busy}, (idx == DEPTH) ? 32'd0 : 32'd1);
        check("full_done", {31'b0, load_done}, (idx == DEPTH) ? 32'd1 : 32'd0);
      end
      check("full_valid", {31'b0, inst_valid}, 32'd0);
    end
    check("full_budget", idx, DEPTH);
    load_en    = 1'b0;
    load_last  = 1'b0;
    load_start = 1'b0;

    fetch(32'h00000FFC);
    check("full_done_once", {31'b0, load_done}, 32'd0);
    repeat (30) fetch($urandom_range(0, DEPTH - 1) * 4);
    fetch(32'h00000000);
    idle_check();

    // Collision: load_start beats ce in SERVE.
    load_start = 1'b1;
    ce = 1'b1;
    pc_addr = 32'h4;
    step();
    load_start = 1'b0;
    ce = 1'b0;
    check("coll_valid", {31'b0, inst_valid}, 32'd0);
    check("coll_busy", {31'b0, busy}, 32'd1);

    // One word into the session, then reset before the second word's edge.
    model_mem[0] = 32'hA5A50001;
    load_word(32'hA5A50001, 1'b0);
    check("abort_busy_pre", {31'b0, busy}, 32'd1);
    load_en   = 1'b1;
    load_data = 32'hDEADBEEF;
    #2 rst = 1'b0;
    #1;
    check("abort_inst", inst, NOP);
    check("abort_valid", {31'b0, inst_valid}, 32'd0);
    check("abort_err", {31'b0, addr_err}, 32'd0);
    check("abort_done", {31'b0, load_done}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    step();
    check("abort_busy_held", {31'b0, busy}, 32'd0);
    load_en = 1'b0;
    #2 rst = 1'b1;
    ce = 1'b1;
    pc_addr = 32'h4;
    step();
    check("post_rst_done", {31'b0, load_done}, 32'd0);
    check("post_rst_busy", {31'b0, busy}, 32'd0);
    check("post_rst_valid", {31'b0, inst_valid}, 32'd0);
    ce = 1'b0;

    // New one-word session; word 1 must still hold its full-load value.
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    model_mem[0] = 32'h5A5A0002;
    load_word(32'h5A5A0002, 1'b1);
    check("reload_done", {31'b0, load_done}, 32'd1);
    fetch(32'h0);
    fetch(32'h4);
    fetch(32'h8);
    fetch(32'h00000FFC);
    idle_check();

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_mem.md
INST_MEM -- requirements
Module: inst_mem

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, meaning log2 of the word count (1024 x 32-bit words).
REQ-002 SHALL have parameter NOP_INST, default 32'h00000000, meaning the word driven when no valid instruction is returned.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port ce, input, 1 bit: fetch request enable from the PC stage.
REQ-006 SHALL have port pc_addr, input, 32 bits: byte address of the requested instruction.
REQ-007 SHALL have port inst, output, 32 bits: returned instruction word.
REQ-008 SHALL have port inst_valid, output, 1 bit: inst carries a response this cycle.
REQ-009 SHALL have port addr_err, output, 1 bit: the response is a fault (misaligned or out of range).
REQ-010 SHALL have port load_start, input, 1 bit: begin a program-load session.
REQ-011 SHALL have port load_en, input, 1 bit: load_data is valid this cycle.
REQ-012 SHALL have port load_last, input, 1 bit: the current load_data is the final word of the session.
REQ-013 SHALL have port load_data, input, 32 bits: program word to store.
REQ-014 SHALL have port load_done, output, 1 bit: one-cycle pulse marking the end of a load session.
REQ-015 SHALL have port busy, output, 1 bit: high while in the LOAD state.

Function
REQ-016 SHALL implement a state machine with three states: IDLE, LOAD and SERVE.
REQ-017 SHALL go IDLE->LOAD or SERVE->LOAD on load_start=1, clearing the word counter wcnt to 0.
REQ-018 SHALL, in LOAD with load_en=1, write load_data to mem[wcnt] and then increment wcnt.
REQ-019 SHALL leave LOAD for SERVE after the write in which load_en=1 and either load_last=1 or wcnt=2^DEPTH_LOG2-1, pulsing load_done for exactly the following cycle; wcnt SHALL never wrap.
REQ-020 SHALL ignore load_start while in LOAD, and SHALL ignore load_last when load_en=0.
REQ-021 SHALL, in SERVE with ce=1 at edge N, drive inst_valid=1 in cycle N+1 (one-cycle latency).
REQ-022 SHALL return inst = mem[pc_addr[DEPTH_LOG2+1:2]] for a legal request.
REQ-023 SHALL treat a request as faulting if pc_addr[1:0]!=0 or any of pc_addr[31:DEPTH_LOG2+2] is nonzero; for such a request the response SHALL be inst=NOP_INST with addr_err=1 and inst_valid=1.
REQ-024 SHALL, in SERVE with ce=0, drive inst_valid=0, addr_err=0 and inst=NOP_INST in the next cycle.
REQ-025 SHALL, in IDLE or LOAD, drive inst_valid=0, addr_err=0 and inst=NOP_INST regardless of ce; requests are dropped, not queued.
REQ-026 SHALL give load_start priority over a simultaneous ce in SERVE: no response in the next cycle and no memory read.
REQ-027 SHALL accept back-to-back requests in SERVE, one response per cycle, in request order.
REQ-028 SHALL drive busy=1 exactly when the state is LOAD.

Reset
REQ-029 SHALL, on rst=0, immediately force state=IDLE, wcnt=0, inst=NOP_INST, inst_valid=0, addr_err=0, load_done=0 and busy=0.
REQ-030 SHALL leave memory contents unchanged by reset; a reset during LOAD SHALL abort the session with no load_done, keeping words already written.
REQ-031 SHALL resume edge-triggered operation from the first rising clk edge after rst returns to 1.

Verification
REQ-032 Load: load_start, then words 0x24010001, 0x24020002, 0x00221820 with load_last on the third -> busy=1 for 3 cycles, load_done pulses once, state becomes SERVE.
REQ-033 Fetch: ce=1 with pc_addr 0x0, 0x4, 0x8 on consecutive cycles -> inst is 0x24010001, 0x24020002, 0x00221820 on the following cycles with inst_valid=1 and addr_err=0.
REQ-034 Faults: pc_addr=0x00000006 -> inst=0x00000000, addr_err=1, inst_valid=1; pc_addr=0x00001000 with DEPTH_LOG2=10 -> same response.
REQ-035 Full load: 1024 words with load_last=0 throughout -> session ends at wcnt=1023 with load_done pulsed; word 1023 is readable at 0x00000FFC.
REQ-036 Collision and reset: load_start with ce=1 in SERVE -> inst_valid=0 next cycle and busy=1; rst=0 mid-LOAD -> outputs at reset values immediately, state IDLE, no load_done.
REQ-037 Idle drop: ce=1 before any load -> inst_valid stays 0 and inst stays NOP_INST.
